// File: rtl/cdma_line_seq_if.sv
// Line-command handshake between the CDMA line sequencer (master) and the
// AXI read/write engines (slave).
interface cdma_line_seq_if;
  logic        rd_cmd_vld;
  logic        rd_cmd_rdy;
  logic [31:0] rd_cmd_addr;
  logic [15:0] rd_cmd_len;
  logic        wr_cmd_vld;
  logic        wr_cmd_rdy;
  logic [31:0] wr_cmd_addr;
  logic [15:0] wr_cmd_len;
  logic        wr_line_done;

  modport master (
    output rd_cmd_vld, rd_cmd_addr, rd_cmd_len,
    output wr_cmd_vld, wr_cmd_addr, wr_cmd_len,
    input  rd_cmd_rdy, wr_cmd_rdy, wr_line_done
  );

  modport slave (
    input  rd_cmd_vld, rd_cmd_addr, rd_cmd_len,
    input  wr_cmd_vld, wr_cmd_addr, wr_cmd_len,
    output rd_cmd_rdy, wr_cmd_rdy, wr_line_done
  );
endinterface

// File: rtl/cdma_line_seq.sv
// 2D line sequencer: one read/write line-command pair per line, bounded
// outstanding write lines, one-cycle command-end pulse.
//   state   | meaning
//   S_IDLE  | waiting for dma_cmd_sof
//   S_ISSUE | issuing line pairs, line_cnt = line in progress
//   S_DRAIN | all lines issued, waiting for outstanding writes to finish
//   S_END   | dma_cmd_end high for this cycle
module cdma_line_seq #(
  parameter int unsigned MAX_OUTSTD = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   dma_cmd_sof,
  input  logic [31:0]            cfg_sar,
  input  logic [31:0]            cfg_dar,
  input  logic [15:0]            cfg_trans_xsize,
  input  logic [15:0]            cfg_trans_ysize,
  input  logic [15:0]            cfg_sa_ystep,
  input  logic [15:0]            cfg_da_ystep,
  input  logic                   cfg_dma_halt,
  cdma_line_seq_if.master        line_if,
  output logic                   dma_cmd_end,
  output logic                   seq_busy,
  output logic [15:0]            line_cnt,
  output logic                   seq_err
);

  localparam logic [3:0] LP_MAX = 4'(MAX_OUTSTD);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_END} state_t;

  state_t      r_state;
  logic        r_rd_vld;
  logic        r_wr_vld;
  logic        r_pair_act;
  logic        r_end;
  logic        r_busy;
  logic        r_err;
  logic [31:0] r_rd_acc;
  logic [31:0] r_wr_acc;
  logic [15:0] r_xsize;
  logic [15:0] r_ysize;
  logic [15:0] r_sa_ystep;
  logic [15:0] r_da_ystep;
  logic [15:0] r_line_cnt;
  logic [3:0]  r_outstd;

  logic        w_pair_done;
  logic        w_dec;
  logic        w_spurious;
  logic [3:0]  w_outstd_nxt;
  logic        w_can_raise;

  // A pair completes once neither half is still waiting for its handshake.
  assign w_pair_done  = (r_state == S_ISSUE) & r_pair_act
                      & ~(r_rd_vld & ~line_if.rd_cmd_rdy)
                      & ~(r_wr_vld & ~line_if.wr_cmd_rdy);
  assign w_dec        = line_if.wr_line_done & (r_outstd != 4'd0);
  assign w_spurious   = line_if.wr_line_done & (r_outstd == 4'd0);
  assign w_outstd_nxt = r_outstd + {3'b000, w_pair_done} - {3'b000, w_dec};
  assign w_can_raise  = ~cfg_dma_halt & (w_outstd_nxt < LP_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_rd_vld   <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_pair_act <= 1'b0;
      r_end      <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_acc   <= '0;
      r_wr_acc   <= '0;
      r_xsize    <= '0;
      r_ysize    <= '0;
      r_sa_ystep <= '0;
      r_da_ystep <= '0;
      r_line_cnt <= '0;
      r_outstd   <= '0;
    end else begin
      r_outstd <= w_outstd_nxt;
      case (r_state)
        S_IDLE: begin
          if (dma_cmd_sof) begin
            r_xsize    <= cfg_trans_xsize;
            r_ysize    <= cfg_trans_ysize;
            r_sa_ystep <= cfg_sa_ystep;
            r_da_ystep <= cfg_da_ystep;
            r_rd_acc   <= cfg_sar;
            r_wr_acc   <= cfg_dar;
            r_line_cnt <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_rd_vld   <= w_can_raise;
            r_wr_vld   <= w_can_raise;
            r_pair_act <= w_can_raise;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_pair_done) begin
            r_rd_acc <= r_rd_acc + {16'h0000, r_sa_ystep};
            r_wr_acc <= r_wr_acc + {16'h0000, r_da_ystep};
            if (r_line_cnt == r_ysize) begin
              r_rd_vld   <= 1'b0;
              r_wr_vld   <= 1'b0;
              r_pair_act <= 1'b0;
              r_state    <= S_DRAIN;
            end else begin
              r_line_cnt <= r_line_cnt + 16'd1;
              r_rd_vld   <= w_can_raise;
              r_wr_vld   <= w_can_raise;
              r_pair_act <= w_can_raise;
            end
          end else if (!r_pair_act) begin
            r_rd_vld   <= w_can_raise;
            r_wr_vld   <= w_can_raise;
            r_pair_act <= w_can_raise;
          end else begin
            // Halt never retracts a raised valid; each half waits for its own rdy.
            if (line_if.rd_cmd_rdy) r_rd_vld <= 1'b0;
            if (line_if.wr_cmd_rdy) r_wr_vld <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_outstd_nxt == 4'd0) begin
            r_end   <= 1'b1;
            r_state <= S_END;
          end
        end
        S_END: begin
          r_end   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_spurious) r_err <= 1'b1;
    end
  end

  assign line_if.rd_cmd_vld  = r_rd_vld;
  assign line_if.rd_cmd_addr = r_rd_acc;
  assign line_if.rd_cmd_len  = r_xsize;
  assign line_if.wr_cmd_vld  = r_wr_vld;
  assign line_if.wr_cmd_addr = r_wr_acc;
  assign line_if.wr_cmd_len  = r_xsize;
  assign dma_cmd_end         = r_end;
  assign seq_busy            = r_busy;
  assign line_cnt            = r_line_cnt;
  assign seq_err             = r_err;

endmodule

// File: doc/cdma_line_seq.md
# cdma_line_seq

2D line sequencer for the CDMA engine. On each command start pulse from the configuration block it snapshots the 2D transfer parameters. It then issues one read-line command and one write-line command per line to the AXI read/write engines, tracks outstanding write lines, honours halt, and returns the one-cycle command-end pulse that drives linked-list fetch and busy status in the configuration block.

## Interface
- MAX_OUTSTD, 4: maximum issued-but-uncompleted write lines (1..15).
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- dma_cmd_sof  in  1  1T pulse: start command with current cfg values
- cfg_sar / cfg_dar  in  32  source / destination byte base address
- cfg_trans_xsize  in  16  line byte size, count from 0
- cfg_trans_ysize  in  16  line count, count from 0
- cfg_sa_ystep / cfg_da_ystep  in  16  per-line address offset, unsigned
- cfg_dma_halt  in  1  1: issue no new line commands
- rd_cmd_vld  out  1  read-line command valid
- rd_cmd_rdy  in  1  read engine accepts
- rd_cmd_addr  out  32  read line start address
- rd_cmd_len  out  16  = shadow xsize
- wr_cmd_vld  out  1  write-line command valid
- wr_cmd_rdy  in  1  write engine accepts
- wr_cmd_addr  out  32  write line start address
- wr_cmd_len  out  16  = shadow xsize
- wr_line_done  in  1  1T pulse: one write line fully responded
- dma_cmd_end  out  1  1T pulse: command complete
- seq_busy  out  1  state != IDLE
- line_cnt  out  16  index of line currently being issued
- seq_err  out  1  sticky: wr_line_done with zero outstanding

## Operation
- States: IDLE, ISSUE, DRAIN, END.
- IDLE: on dma_cmd_sof:
  - Latch all cfg_* except halt into shadow registers.
  - Set rd/wr address accumulators to sar/dar, line_cnt=0, clear seq_err.
  - Go to ISSUE.
  - dma_cmd_sof outside IDLE is ignored.
- ISSUE, pair issue:
  - Raise rd_cmd_vld and wr_cmd_vld together when halt=0 and outstanding<MAX_OUTSTD.
  - Each valid drops independently after its own vld&rdy handshake.
  - Addr/len are stable while valid is high.
  - Once raised, a valid stays high until its handshake, regardless of halt.
- Pair complete (both handshakes done, possibly in different cycles):
  - outstanding+1.
  - Accumulators advance: rd += {16'b0,sa_ystep}, wr += {16'b0,da_ystep}, modulo 2^32 (wrap, no error).
  - If line_cnt==ysize, go to DRAIN; otherwise line_cnt+1.
- Outstanding counter, 4 bits:
  - +1 on pair complete, -1 on wr_line_done.
  - Both in one cycle: unchanged.
  - wr_line_done at zero: count stays 0, seq_err=1.
- DRAIN: when outstanding==0 (counting same-cycle decrement), go to END.
- END: dma_cmd_end=1 for this single cycle, then IDLE.
- Halt only gates raising new valids. A halt in DRAIN does not block END.
- Async reset at any point: all state cleared and every output 0. Commands in flight at the engines are not tracked.

## Timing
- Reset values: every output 0; state IDLE; outstanding 0.
- sof sampled at edge E: rd/wr_cmd_vld high in the cycle after E, with rd_cmd_addr=cfg_sar and wr_cmd_addr=cfg_dar.
- Pair completing at edge E: next pair's valids high in the cycle after E when not stalled. Back-to-back lines have no bubble when both rdy are held high.
- Minimum command (1 line, rdy high, done 2 cycles after accept):
  - sof at cycle 0, vld in cycle 1, done in cycle 3.
  - ISSUE to DRAIN at end of cycle 1; END in cycle 4, with dma_cmd_end high in cycle 4.
  - seq_busy high in cycles 1..4.
- Stall on outstanding==MAX_OUTSTD: wr_line_done sampled at edge E lets a new valid go high in the cycle after E.
- cfg_* changes after the sof edge have no effect on the running command.

## Test plan
- Single line: sar=0x1000, dar=0x2000, xsize=63, ysize=0. Expect one rd/wr pair (0x1000, 0x2000, len 63), then one dma_cmd_end after done, then seq_busy=0.
- 3 lines: sa_ystep=0x100, da_ystep=0x80, rdy always 1. Expect rd addrs 0x1000/0x1100/0x1200 and wr addrs 0x2000/0x2080/0x2100 back-to-back; end follows the third done.
- MAX_OUTSTD=2, ysize=4, withhold done. Expect exactly 2 pairs issued and the valids low. Each done pulse releases one more pair. End after the 5th done.
- Asymmetric backpressure: rd_cmd_rdy delayed 3 cycles and wr immediate. Expect wr_cmd_vld low while rd_cmd_vld holds; the next pair waits; outstanding increments once per line.
- Halt set with rd_cmd_vld high: that command still completes handshake, no new valids rise. Halt release resumes the next line with the correct address. Address wrap: sar=0xFFFFFF80, step 0x100 gives the next addr 0x00000080.
- Spurious done in IDLE sets seq_err=1. sof while busy is ignored (line_cnt not reset). rstn asserted mid-ISSUE clears all outputs immediately.
